// File: rtl/cpu_ctrl.sv
// Z80 companion controller: paired clock enables, programmable bus wait states
// and a prioritised, maskable edge-triggered interrupt controller with IM2 vectors.
module cpu_ctrl #(
  parameter int         DIV    = 4,
  parameter int         NINT   = 4,
  parameter int         MWAIT  = 0,
  parameter int         IOWAIT = 0,
  parameter logic [7:0] VBASE  = 8'hE0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            cep,
  output logic            cen,
  input  logic            mreq,
  input  logic            iorq,
  input  logic            m1,
  output logic            wait_n,
  input  logic [NINT-1:0] irq,
  input  logic [NINT-1:0] imask,
  output logic            int_n,
  output logic            iack,
  output logic [7:0]      ivec
);

  localparam int         CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [7:0] SPUR = VBASE + 8'(2 * NINT);

  logic [CW-1:0]   cnt_reg;
  logic            mreq_reg, iorq_reg, m1_reg;
  logic [3:0]      wcnt_reg, wcnt_next;
  logic [NINT-1:0] sync1_reg, sync2_reg, sync3_reg;
  logic [NINT-1:0] pend_reg, pend_next, rise, clr;
  logic [2:0]      sel;
  logic            any;
  logic            cyc_mem, cyc_io, ack_go;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      cep     <= 1'b0;
      cen     <= 1'b0;
    end else begin
      cep     <= (cnt_reg == '0);
      cen     <= (cnt_reg == CW'(DIV / 2));
      cnt_reg <= (cnt_reg == CW'(DIV - 1)) ? '0 : cnt_reg + CW'(1);
    end
  end

  // Strobe history is only advanced on cep so starts are seen between CPU T-state samples.
  assign cyc_mem = cep & mreq_reg & ~mreq;
  assign cyc_io  = cep & iorq_reg & ~iorq;
  assign ack_go  = cep & (m1_reg | iorq_reg) & ~m1 & ~iorq;

  always_comb begin
    wcnt_next = wcnt_reg;
    if (cyc_mem)
      wcnt_next = 4'(MWAIT);
    else if (cyc_io)
      wcnt_next = m1 ? 4'(IOWAIT) : 4'd0;
    else if (cep && wcnt_reg != 4'd0)
      wcnt_next = wcnt_reg - 4'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NINT; gi++) begin : g_sync
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
          sync3_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= irq[gi];
          sync2_reg[gi] <= sync1_reg[gi];
          sync3_reg[gi] <= sync2_reg[gi];
        end
      end
      assign rise[gi] = sync2_reg[gi] & ~sync3_reg[gi];
    end
  endgenerate

  always_comb begin
    sel = 3'd0;
    any = 1'b0;
    for (int i = NINT - 1; i >= 0; i--) begin
      if (pend_reg[i]) begin
        sel = 3'(i);
        any = 1'b1;
      end
    end
  end

  // A fresh edge is OR-ed after the ack clear so it survives a same-clock acknowledge.
  assign clr       = (ack_go && any) ? (NINT'(1) << sel) : '0;
  assign pend_next = ((pend_reg & ~clr) | rise) & imask;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mreq_reg <= 1'b1;
      iorq_reg <= 1'b1;
      m1_reg   <= 1'b1;
      wcnt_reg <= 4'd0;
      wait_n   <= 1'b1;
      pend_reg <= '0;
      int_n    <= 1'b1;
      iack     <= 1'b0;
      ivec     <= VBASE;
    end else begin
      if (cep) begin
        mreq_reg <= mreq;
        iorq_reg <= iorq;
        m1_reg   <= m1;
      end
      wcnt_reg <= wcnt_next;
      wait_n   <= (wcnt_next == 4'd0);
      pend_reg <= pend_next;
      int_n    <= ~|pend_reg;
      if (ack_go) begin
        iack <= 1'b1;
        ivec <= any ? (VBASE + {4'b0000, sel, 1'b0}) : SPUR;
      end else if (cep && iorq) begin
        iack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl (DIV=4, NINT=4, MWAIT=2, IOWAIT=0): table of
// per-cep-sample steps plus hand sequences for wait timing, masking and resets.
module tb_cpu_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cep, cen, wait_n, int_n, iack;
  logic       mreq = 1'b1, iorq = 1'b1, m1 = 1'b1;
  logic [3:0] irq = 4'b0000, imask = 4'b0000;
  logic [7:0] ivec;

  int n_tests = 0;
  int n_fail  = 0;
  int tk      = 0;
  int low;

  typedef struct packed {
    logic       mreq, iorq, m1;
    logic [3:0] irq, imask;
    logic       wait_n, int_n, iack;
    logic [7:0] ivec;
  } vec_t;

  vec_t tbl [13];

  cpu_ctrl #(.DIV(4), .NINT(4), .MWAIT(2), .IOWAIT(0), .VBASE(8'hE0)) dut (
    .clock(clock), .reset(reset), .cep(cep), .cen(cen),
    .mreq(mreq), .iorq(iorq), .m1(m1), .wait_n(wait_n),
    .irq(irq), .imask(imask), .int_n(int_n), .iack(iack), .ivec(ivec)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    tk++;
  endtask

  // DUT samples strobes on edges tk = 2, 6, 10, ... after reset release.
  task automatic next_sample();
    do tick(); while (tk % 4 != 2);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'b0100, 4'b1111, 1'b1, 1'b0, 1'b0, 8'hE0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0, 8'hE0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 8'hE0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 8'hE0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 8'hE4};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 8'hE4};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b1, 1'b0, 8'hE4};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 8'hE4};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 8'hE8};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 8'hE8};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 8'hE8};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 8'hE8};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 4'b1000, 4'b1111, 1'b1, 1'b0, 1'b0, 8'hE8};

    // Held in reset
    tick();
    tick();
    chk1("rst_cep", cep, 1'b0);
    chk1("rst_cen", cen, 1'b0);
    chk1("rst_wait_n", wait_n, 1'b1);
    chk1("rst_int_n", int_n, 1'b1);
    chk1("rst_iack", iack, 1'b0);
    chk8("rst_ivec", ivec, 8'hE0);

    reset = 1'b1;
    tk = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk1($sformatf("cep_clk%0d", k - 1), cep, ((k - 1) % 4) == 0);
      chk1($sformatf("cen_clk%0d", k - 1), cen, ((k - 1) % 4) == 2);
    end

    // Memory cycle: wait_n low for exactly 2 cep periods
    next_sample();
    mreq = 1'b0;
    next_sample();
    low = 0;
    for (int i = 0; i < 16; i++) begin
      if (wait_n === 1'b0) low++;
      tick();
    end
    chki("mem_wait_clocks", low, 8);
    $display("[TB] mem cycle: wait_n low for %0d clocks", low);

    // I/O cycle with IOWAIT=0: no wait
    mreq = 1'b1;
    iorq = 1'b0;
    low = 0;
    for (int i = 0; i < 16; i++) begin
      if (wait_n === 1'b0) low++;
      tick();
    end
    chki("io_wait_clocks", low, 0);
    $display("[TB] io cycle: wait_n low for %0d clocks", low);
    iorq = 1'b1;

    for (int s = 0; s < 13; s++) begin
      mreq  = tbl[s].mreq;
      iorq  = tbl[s].iorq;
      m1    = tbl[s].m1;
      irq   = tbl[s].irq;
      imask = tbl[s].imask;
      next_sample();
      chk1($sformatf("step%0d_wait_n", s), wait_n, tbl[s].wait_n);
      chk1($sformatf("step%0d_int_n", s), int_n, tbl[s].int_n);
      chk1($sformatf("step%0d_iack", s), iack, tbl[s].iack);
      chk8($sformatf("step%0d_ivec", s), ivec, tbl[s].ivec);
      $display("[TB] step %0d: iorq=%b m1=%b irq=%b imask=%b -> wait_n=%b int_n=%b iack=%b ivec=%h",
               s, iorq, m1, irq, imask, wait_n, int_n, iack, ivec);
    end

    // Clearing the mask of the only pending source drops int within 2 clocks
    irq   = 4'b0000;
    imask = 4'b0111;
    tick();
    tick();
    chk1("mask_clear_int_n", int_n, 1'b1);
    $display("[TB] mask clear: int_n=%b", int_n);

    // Edge on source 1 coincident with its acknowledge keeps it pending
    next_sample();
    imask = 4'b1111;
    irq   = 4'b0010;
    next_sample();
    chk1("pend1_set_int_n", int_n, 1'b0);
    irq = 4'b0000;
    next_sample();
    m1   = 1'b0;
    iorq = 1'b0;
    tick();
    irq = 4'b0010;
    next_sample();
    chk8("coinc_ivec", ivec, 8'hE2);
    chk1("coinc_iack", iack, 1'b1);
    m1   = 1'b1;
    iorq = 1'b1;
    irq  = 4'b0000;
    next_sample();
    chk1("coinc_iack_drop", iack, 1'b0);
    chk1("coinc_int_n", int_n, 1'b0);
    m1   = 1'b0;
    iorq = 1'b0;
    next_sample();
    chk8("coinc_reack_ivec", ivec, 8'hE2);
    $display("[TB] coincident edge/ack: ivec=%h int_n=%b", ivec, int_n);
    m1   = 1'b1;
    iorq = 1'b1;
    next_sample();

    // Reset in the middle of a wait with an interrupt pending
    mreq = 1'b0;
    irq  = 4'b0010;
    next_sample();
    chk1("pre_rst_wait_n", wait_n, 1'b0);
    chk1("pre_rst_int_n", int_n, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk1("mid_rst_wait_n", wait_n, 1'b1);
    chk1("mid_rst_int_n", int_n, 1'b1);
    chk1("mid_rst_cep", cep, 1'b0);
    chk8("mid_rst_ivec", ivec, 8'hE0);
    $display("[TB] mid-wait reset: wait_n=%b int_n=%b ivec=%h", wait_n, int_n, ivec);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Parametrised CPU control companion for the Z80 core: generates the paired positive/negative clock enables from the system clock, inserts programmable wait states on memory and I/O cycles, and runs a prioritised, maskable multi-source interrupt controller with IM2-style vector delivery on interrupt acknowledge. Sits beside the CPU core at board top level and drives its enable, wait and interrupt inputs from the CPU's own bus strobes.

## Interface

- DIV, 4: clock divide ratio for one CPU T-state; even, ≥4.
- NINT, 4: number of interrupt sources, 1..8.
- MWAIT, 0: extra wait T-states per memory cycle, 0..15.
- IOWAIT, 0: extra wait T-states per I/O cycle, 0..15, added to the core's built-in one.
- VBASE, 8'hE0: vector base; low 4 bits must be 0.

- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cep  out  1  CPU positive-edge enable, one clock wide.
- cen  out  1  CPU negative-edge enable, one clock wide.
- mreq  in  1  CPU memory request, active-low.
- iorq  in  1  CPU I/O request, active-low.
- m1  in  1  CPU opcode fetch, active-low.
- wait_n  out  1  CPU wait request, active-low.
- irq  in  NINT  asynchronous interrupt requests, rising-edge triggered.
- imask  in  NINT  per-source enable, 1 = enabled.
- int  out  1  CPU interrupt request, active-low, level.
- iack  out  1  high while an interrupt-acknowledge cycle is active.
- ivec  out  8  vector byte for the CPU data mux, valid while iack=1.

## Operation

- Enable generator: counter 0..DIV-1, free-running, wraps to 0. cep=1 on the clock where count==0; cen=1 where count==DIV/2. Never both high.
- Bus strobes are sampled only on cep. A cycle start is a 1→0 transition of mreq or iorq between successive cep samples.
- Wait states: on a cycle start, a 4-bit counter loads MWAIT (mreq), IOWAIT (iorq without m1), or 0 (iorq with m1). wait_n = 0 while counter ≠ 0. Counter decrements on each cep after load. MWAIT=0 or IOWAIT=0 means wait_n never falls for that cycle type.
- Interrupt inputs: each irq bit passes through a 2-flop synchroniser and then a rising-edge detector. An edge on source k with imask[k]=1 sets pend[k]. An edge on a masked source is discarded. Clearing imask[k] clears pend[k] on the next clock.
- int = ~|pend, registered.
- Acknowledge: on a cep sample where m1=0 and iorq=0 after a sample where either was high, the block selects the lowest-index pending source s. It registers ivec = VBASE + 2*s, sets iack=1 and clears pend[s].
- iack stays 1 until a cep sample sees iorq=1.
- Acknowledge with no source pending: ivec = VBASE + 2*NINT (spurious vector), iack=1 as normal.
- Simultaneous edge on source s and ack of s in the same clock: the edge wins and pend[s] stays 1.
- Edges on other sources during iack set their pend bits normally.

## Timing

- Reset values (async on reset=0): counter 0, cep=0, cen=0, wait_n=1, int=1, iack=0, ivec=VBASE, pend=0, synchronisers and edge detectors 0.
- After reset release, the first cep occurs on the 1st rising clock edge and the first cen DIV/2 clocks later.
- irq to pend: 3 clocks (2 sync + edge). pend to int: +1 clock.
- wait_n falls 1 clock after the cep that detects a cycle start. It rises 1 clock after the cep on which the counter reaches 0, so a cycle holds exactly MWAIT/IOWAIT cep periods.
- ivec and iack update 1 clock after the detecting cep. int rises 1 clock after the pend clear if no other source is pending.
- Reset asserted mid-cycle clears everything immediately, including an in-progress wait or ack. No state survives.

## Test plan

- DIV=4, reset released: cep at clocks 0,4,8…; cen at 2,6,10…; all outputs at their reset values before release.
- MWAIT=2: mreq falls before a cep → wait_n low for exactly 2 cep periods (8 clocks); iorq cycle with IOWAIT=0 → wait_n stays 1.
- NINT=4, imask=4'b1111, pulse irq[2] then irq[0] → int=0; first ack gives ivec=8'hE0 and clears pend[0]; second ack gives 8'hE4; then int=1.
- imask[1]=0, pulse irq[1] → int stays 1. Set pend[3], then clear imask[3] → int returns to 1 within 2 clocks.
- Ack with pend=0 and NINT=4 → ivec=8'hE8, iack=1 until iorq rises.
- irq[1] edge coincident with the ack of source 1 → pend[1] remains 1 and int stays 0. Assert reset during wait_n=0 → wait_n=1 and int=1 immediately.
